// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core types; this slice carries the mul/div unit's state and control types.
package mips_cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_MULT = 3'd1,
    ALU_DIV  = 3'd2
  } mult_op_enum;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_enum;

  localparam int MULDIV_ITER = 32;

  // Operation attributes captured at acceptance and held until MD_FIX.
  typedef struct packed {
    logic is_div;
    logic res_neg;
    logic rem_neg;
    logic div0;
  } md_ctl_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: whole-word, or per half when split is set.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         split,
  input  logic         neg_hi,
  input  logic         neg_lo,
  output logic [W-1:0] res
);

  localparam int H = W / 2;

  logic [H-1:0] hi_f, lo_f;

  always_comb begin
    hi_f = neg_hi ? -val[W-1:H] : val[W-1:H];
    lo_f = neg_lo ? -val[H-1:0] : val[H-1:0];
    res  = split ? {hi_f, lo_f} : (neg_lo ? -val : val);
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle shift-add multiply / restoring divide owning the HI/LO registers.
module muldiv_hilo
  import mips_cpu_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  mult_op_enum req_op,
  input  logic        req_sign,
  input  word_t       req_a,
  input  word_t       req_b,
  input  logic        cancel,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  word_t       mt_wdata,
  output logic        busy,
  output logic        done,
  output word_t       hi,
  output word_t       lo
);

  localparam int CW = $clog2(ITER);

  muldiv_state_enum state, state_nx;
  logic [CW-1:0]    cnt;
  md_ctl_t          ctl;
  word_t            b_mag, wh, wl;
  logic             accept;

  assign req_ready = (state == MD_IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready && !cancel;

  // Operand magnitudes, one signfix instance per operand
  word_t [1:0] abs_in, abs_out;
  logic  [1:0] abs_neg;

  assign abs_in  = {req_b, req_a};
  assign abs_neg = {req_sign & req_b[31], req_sign & req_a[31]};

  for (genvar i = 0; i < 2; i++) begin : g_abs
    muldiv_signfix #(.W(32)) u_abs (
      .val    (abs_in[i]),
      .split  (1'b0),
      .neg_hi (1'b0),
      .neg_lo (abs_neg[i]),
      .res    (abs_out[i])
    );
  end

  // Shared 33-bit adder: P + (M[0] ? b : 0) for multiply, {R,Q[31]} - b for divide.
  // R < |b| holds across divide steps, so sum[32] is the borrow/sign of T.
  logic [32:0] sh, add_x, add_y, sum;

  always_comb begin
    sh    = {wh, wl[31]};
    add_x = ctl.is_div ? sh : {1'b0, wh};
    add_y = ctl.is_div ? ~{1'b0, b_mag} : (wl[0] ? {1'b0, b_mag} : 33'd0);
    sum   = add_x + add_y + {32'd0, ctl.is_div};
  end

  logic [63:0] fix_res;

  muldiv_signfix #(.W(64)) u_fix (
    .val    ({wh, wl}),
    .split  (ctl.is_div),
    .neg_hi (ctl.rem_neg),
    .neg_lo (ctl.res_neg),
    .res    (fix_res)
  );

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (accept) state_nx = MD_CALC;
      MD_CALC: begin
        if (cancel)                     state_nx = MD_IDLE;
        else if (cnt == CW'(ITER - 1))  state_nx = MD_FIX;
      end
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ctl   <= '0;
      b_mag <= '0;
      wh    <= '0;
      wl    <= '0;
    end else begin
      case (state)
        MD_IDLE: if (accept) begin
          cnt   <= '0;
          ctl   <= '{is_div:  (req_op == ALU_DIV),
                     res_neg: req_sign & (req_a[31] ^ req_b[31]),
                     rem_neg: req_sign & req_a[31],
                     div0:    (req_op == ALU_DIV) && (req_b == '0)};
          b_mag <= abs_out[1];
          wh    <= '0;
          wl    <= abs_out[0];
        end
        MD_CALC: begin
          cnt <= cnt + 1'b1;
          if (ctl.is_div) begin
            if (!sum[32]) begin
              wh <= sum[31:0];
              wl <= {wl[30:0], 1'b1};
            end else begin
              wh <= sh[31:0];
              wl <= {wl[30:0], 1'b0};
            end
          end else begin
            wh <= sum[32:1];
            wl <= {sum[0], wl[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Divide by zero leaves R = |a|, so the fixed HI already equals the original rs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == MD_IDLE) begin
        if (mthi_we) hi <= mt_wdata;
        if (mtlo_we) lo <= mt_wdata;
      end else if (state == MD_FIX && !cancel) begin
        done <= 1'b1;
        hi   <= fix_res[63:32];
        lo   <= ctl.div0 ? 32'hFFFF_FFFF : fix_res[31:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed + scoreboard bench for muldiv_hilo: expected HI/LO queued at issue, popped on done.
module tb_muldiv_hilo;
  import mips_cpu_pkg::*;

  logic        clk, rst_n, req_valid, req_ready, req_sign, cancel;
  logic        mthi_we, mtlo_we, busy, done;
  mult_op_enum req_op;
  word_t       req_a, req_b, mt_wdata, hi, lo;

  muldiv_hilo dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sign(req_sign), .req_a(req_a), .req_b(req_b),
    .cancel(cancel), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_wdata(mt_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { word_t hi; word_t lo; } res_t;
  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input mult_op_enum op, input logic sg,
                                        input word_t a, input word_t b);
    logic signed [63:0] sa, sbv, q, r;
    logic [63:0] p;
    if (op == ALU_MULT) begin
      if (sg) begin
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        p   = sa * sbv;
      end else p = {32'd0, a} * {32'd0, b};
      return p;
    end
    if (b == '0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      q   = sa / sbv;
      r   = sa % sbv;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic issue(input mult_op_enum op, input logic sg, input word_t a, input word_t b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_sign = sg; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue_exp(input mult_op_enum op, input logic sg, input word_t a, input word_t b,
                           input word_t ehi, input word_t elo);
    res_t e;
    e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    issue(op, sg, a, b);
  endtask

  // Called at acceptance edge + 1; samples each following edge + 1 until done.
  task automatic wait_done(input string tag);
    int   n;
    logic bz;
    res_t e;
    n  = 0;
    bz = 1'b1;
    chk({tag, "_done_low_at_accept"}, 64'(done), 64'd0);
    do begin
      if (!busy) bz = 1'b0;
      @(posedge clk);
      #1 n++;
    end while (!done && n < 60);
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busy_throughout"}, 64'(bz), 64'd1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      chk({tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
    end
  endtask

  initial begin
    logic        sawdone;
    logic        sg;
    mult_op_enum op;
    word_t       a, b;
    logic [63:0] m;

    rst_n = 1'b0; req_valid = 1'b0; req_op = ALU_MULT; req_sign = 1'b0;
    req_a = '0; req_b = '0; cancel = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_ready_busy_done", {61'd0, req_ready, busy, done}, {61'd0, 3'b100});
    @(negedge clk) rst_n = 1'b1;

    issue_exp(ALU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu_max");

    issue_exp(ALU_MULT, 1'b1, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done("mult_neg");
    issue_exp(ALU_DIV, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_b2b");

    issue_exp(ALU_DIV, 1'b0, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    wait_done("divu_zero");
    issue_exp(ALU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    wait_done("div_neg_zero");
    issue_exp(ALU_DIV, 1'b1, 32'd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD);
    wait_done("div_negb");
    issue_exp(ALU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    wait_done("div_min_m1");

    // MTHI in idle, MTLO ignored while busy, then cancel mid-multiply
    @(negedge clk); mthi_we = 1'b1; mt_wdata = 32'h1234;
    @(posedge clk); #1 mthi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'h1234);
    issue(ALU_MULT, 1'b0, 32'd5, 32'd5);
    @(negedge clk); mtlo_we = 1'b1; mt_wdata = 32'hDEAD;
    @(posedge clk); #1 mtlo_we = 1'b0;
    chk("mtlo_busy_ignored", 64'(lo), 64'h8000_0000);
    repeat (8) @(posedge clk);
    @(negedge clk) cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    chk("cancel_ready", {62'd0, req_ready, done}, {62'd0, 2'b10});
    chk("cancel_hilo", {hi, lo}, {32'h1234, 32'h8000_0000});
    sawdone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) sawdone = 1'b1;
    end
    chk("cancel_no_done", 64'(sawdone), 64'd0);

    // cancel in idle blocks acceptance but not MTLO
    @(negedge clk);
    req_valid = 1'b1; req_op = ALU_MULT; req_sign = 1'b0; req_a = 32'd2; req_b = 32'd2;
    cancel = 1'b1; mtlo_we = 1'b1; mt_wdata = 32'h55;
    @(posedge clk); #1 req_valid = 1'b0; cancel = 1'b0; mtlo_we = 1'b0;
    chk("idle_cancel_blocks", 64'(req_ready), 64'd1);
    chk("idle_cancel_mtlo", 64'(lo), 64'h55);

    for (int i = 0; i < 6; i++) begin
      op = ($urandom_range(0, 1) == 1) ? ALU_DIV : ALU_MULT;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = (i % 2 == 1) ? $urandom_range(1, 100) : $urandom;
      if (b == '0) b = 32'd3;
      m  = model(op, sg, a, b);
      issue_exp(op, sg, a, b, m[63:32], m[31:0]);
      wait_done($sformatf("rand%0d", i));
    end

    // async reset mid-divide
    issue(ALU_DIV, 1'b0, 32'd1000, 32'd7);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_hilo", {hi, lo}, 64'd0);
    chk("midreset_state", {62'd0, req_ready, done}, {62'd0, 2'b10});
    @(negedge clk) rst_n = 1'b1;
    sawdone = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) sawdone = 1'b1;
    end
    chk("midreset_no_done", 64'(sawdone), 64'd0);
    issue_exp(ALU_MULT, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);
    wait_done("multu_after_reset");
    @(posedge clk); #1;
    chk("done_single_pulse", 64'(done), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
